// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV M-extension execute unit.
//   - MD_* operation codes (4-bit; bit 3 selects the 32-bit word forms)
//   - FSM state encoding
//   - operation-class helper functions
package muldiv_pkg;

  localparam logic [3:0] MD_MUL    = 4'd0;
  localparam logic [3:0] MD_MULH   = 4'd1;
  localparam logic [3:0] MD_MULHSU = 4'd2;
  localparam logic [3:0] MD_MULHU  = 4'd3;
  localparam logic [3:0] MD_DIV    = 4'd4;
  localparam logic [3:0] MD_DIVU   = 4'd5;
  localparam logic [3:0] MD_REM    = 4'd6;
  localparam logic [3:0] MD_REMU   = 4'd7;
  localparam logic [3:0] MD_MULW   = 4'd8;
  localparam logic [3:0] MD_DIVW   = 4'd12;
  localparam logic [3:0] MD_DIVUW  = 4'd13;
  localparam logic [3:0] MD_REMW   = 4'd14;
  localparam logic [3:0] MD_REMUW  = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  function automatic logic is_div(input logic [3:0] op);
    return op[2];
  endfunction

  // Only meaningful for divide-class ops.
  function automatic logic is_rem(input logic [3:0] op);
    return op[1];
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic is_signed1(input logic [3:0] op);
    case (op)
      MD_MULH, MD_MULHSU, MD_DIV, MD_REM, MD_MULW, MD_DIVW, MD_REMW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed2(input logic [3:0] op);
    case (op)
      MD_MULH, MD_DIV, MD_REM, MD_MULW, MD_DIVW, MD_REMW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the EX stage and muldiv_unit.
//   start_i/op_i/opdata1_i/opdata2_i/flush_i : EX -> unit
//   busy_o/done_o/result_o                   : unit -> EX
// master = EX side, slave = muldiv_unit.
interface muldiv_if #(parameter int XLEN = 64);
  logic            start_i;
  logic [3:0]      op_i;
  logic [XLEN-1:0] opdata1_i;
  logic [XLEN-1:0] opdata2_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: iterative radix-2 non-restoring unsigned divider.
//   load_i      : capture dividend/divisor and start XLEN (or 32) iterations
//   dividend_i  : unsigned dividend (low 32 bits used when width32_i)
//   divisor_i   : unsigned, non-zero divisor
//   width32_i   : run 32 iterations on a 32-bit dividend
//   q_o         : quotient
//   r_o         : remainder, already restored to the non-negative range
//   last_o      : high during the cycle of the final iteration
module muldiv_div_core #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            width32_i,
  output logic [XLEN-1:0] q_o,
  output logic [XLEN-1:0] r_o,
  output logic            last_o
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] dd_q, dd_d, d_q, d_d, q_q, q_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN+1:0] rem_sh, d_ext, rem_nx;

  always_comb begin
    cnt_d = cnt_q;
    dd_d  = dd_q;
    d_d   = d_q;
    q_d   = q_q;
    rem_d = rem_q;
    // {rem, next dividend bit} is 2*rem + bit; one extra bit of headroom.
    rem_sh = {rem_q, dd_q[XLEN-1]};
    d_ext  = {2'b00, d_q};
    rem_nx = rem_q[XLEN] ? rem_sh + d_ext : rem_sh - d_ext;
    if (load_i) begin
      cnt_d = width32_i ? CW'(32) : CW'(XLEN);
      // A 32-bit dividend is left-aligned so its MSB is shifted out first.
      dd_d  = width32_i ? (dividend_i << (XLEN - 32)) : dividend_i;
      d_d   = divisor_i;
      q_d   = '0;
      rem_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      dd_d  = dd_q << 1;
      rem_d = rem_nx[XLEN:0];
      q_d   = {q_q[XLEN-2:0], ~rem_nx[XLEN]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      dd_q  <= '0;
      d_q   <= '0;
      q_q   <= '0;
      rem_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dd_q  <= dd_d;
      d_q   <= d_d;
      q_q   <= q_d;
      rem_q <= rem_d;
    end
  end

  assign q_o    = q_q;
  assign r_o    = rem_q[XLEN] ? rem_q[XLEN-1:0] + d_q : rem_q[XLEN-1:0];
  assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV M-extension execute unit (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : muldiv_if.slave (start/op/operands/flush in; busy/done/result out)
// Optional: MULDIV_WORD_OPS_EN adds MULW/DIVW/DIVUW/REMW/REMUW (XLEN must be 64).
//
// state | meaning
// IDLE  | waiting for start_i
// MUL   | product settling over MUL_LAT-1 cycles from latched operands
// DIV   | divider core iterating, one quotient bit per cycle
// FIX   | apply quotient/remainder signs, stage result
// DONE  | done_o pulse, result_o presents the new value
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int MUL_LAT = 2
) (
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  bus
);

`ifdef MULDIV_WORD_OPS_EN
  localparam bit WORD_EN = 1'b1;
  if (XLEN != 64) begin : g_word_xlen_chk
    $error("MULDIV_WORD_OPS_EN requires XLEN == 64");
  end
`else
  localparam bit WORD_EN = 1'b0;
`endif

  if (MUL_LAT < 1 || MUL_LAT > 4) begin : g_mul_lat_chk
    $error("MUL_LAT must be 1..4");
  end

  localparam logic [2:0]      MUL_CNT0 = 3'(MUL_LAT - 1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic signed [XLEN-1:0] t;
    t = v << (XLEN - 32);
    return t >>> (XLEN - 32);
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
    return (v << (XLEN - 32)) >> (XLEN - 32);
  endfunction

  // Word ops deliver bits [31:0] sign-extended.
  function automatic logic [XLEN-1:0] fit(input logic [3:0] op, input logic [XLEN-1:0] v);
    return (WORD_EN && is_word(op)) ? sext32(v) : v;
  endfunction

  // XLEN+1-bit operands carry the signedness, so one signed multiply covers all forms.
  function automatic logic [XLEN-1:0] mul_res(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic signed [XLEN:0]     sa, sb;
    logic signed [2*XLEN+1:0] p;
    sa = $signed({is_signed1(op) & a[XLEN-1], a});
    sb = $signed({is_signed2(op) & b[XLEN-1], b});
    p  = sa * sb;
    return (op == MD_MUL || op == MD_MULW) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  md_state_e       state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] ax_q, ax_d, bx_q, bx_d;
  logic [XLEN-1:0] pend_q, pend_d, result_q, result_d;
  logic [3:0]      op_q, op_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic            legal, word_in, neg_a, neg_b, div0, ovf, div_load, div_last;
  logic [XLEN-1:0] ax, bx, abs_a, abs_b, spec_res, div_q, div_r, q_fix, r_fix;

  always_comb begin
    legal = 1'b0;
    case (bus.op_i)
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
      MD_DIV, MD_DIVU, MD_REM, MD_REMU:                legal = 1'b1;
      MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW:   legal = WORD_EN;
      default:                                         legal = 1'b0;
    endcase
  end

  assign word_in = WORD_EN && is_word(bus.op_i);
  assign ax    = word_in ? (is_signed1(bus.op_i) ? sext32(bus.opdata1_i) : zext32(bus.opdata1_i))
                         : bus.opdata1_i;
  assign bx    = word_in ? (is_signed2(bus.op_i) ? sext32(bus.opdata2_i) : zext32(bus.opdata2_i))
                         : bus.opdata2_i;
  assign neg_a = is_signed1(bus.op_i) & ax[XLEN-1];
  assign neg_b = is_signed2(bus.op_i) & bx[XLEN-1];
  assign abs_a = neg_a ? -ax : ax;
  assign abs_b = neg_b ? -bx : bx;
  assign div0  = (bx == '0);
  assign ovf   = is_signed1(bus.op_i) &&
                 (word_in ? (ax[31:0] == 32'h8000_0000 && bx[31:0] == 32'hFFFF_FFFF)
                          : (ax == XMIN && bx == '1));
  assign spec_res = div0 ? (is_rem(bus.op_i) ? ax : '1)
                         : (is_rem(bus.op_i) ? '0 : ax);
  assign q_fix = q_neg_q ? -div_q : div_q;
  assign r_fix = r_neg_q ? -div_r : div_r;

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .width32_i  (word_in),
    .q_o        (div_q),
    .r_o        (div_r),
    .last_o     (div_last)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ax_d     = ax_q;
    bx_d     = bx_q;
    op_d     = op_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    pend_d   = pend_q;
    result_d = result_q;
    div_load = 1'b0;
    if (bus.flush_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.start_i) begin
          op_d = bus.op_i;
          if (!legal) begin
            pend_d  = '0;
            state_d = ST_DONE;
          end else if (is_div(bus.op_i)) begin
            if (div0 || ovf) begin
              pend_d  = fit(bus.op_i, spec_res);
              state_d = ST_DONE;
            end else begin
              div_load = 1'b1;
              q_neg_d  = neg_a ^ neg_b;
              r_neg_d  = neg_a;
              state_d  = ST_DIV;
            end
          end else begin
            ax_d = ax;
            bx_d = bx;
            if (MUL_LAT == 1) begin
              pend_d  = fit(bus.op_i, mul_res(bus.op_i, ax, bx));
              state_d = ST_DONE;
            end else begin
              cnt_d   = MUL_CNT0;
              state_d = ST_MUL;
            end
          end
        end
        // Product path from ax_q/bx_q is given MUL_LAT-1 cycles to settle.
        ST_MUL: begin
          if (cnt_q == 3'd1) begin
            pend_d  = fit(op_q, mul_res(op_q, ax_q, bx_q));
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        ST_DIV: if (div_last) state_d = ST_FIX;
        ST_FIX: begin
          pend_d  = fit(op_q, is_rem(op_q) ? r_fix : q_fix);
          state_d = ST_DONE;
        end
        // Visible result only commits here, so a flush in DONE leaves it untouched.
        ST_DONE: begin
          result_d = pend_q;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ax_q     <= '0;
      bx_q     <= '0;
      op_q     <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      pend_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ax_q     <= ax_d;
      bx_q     <= bx_d;
      op_q     <= op_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      pend_q   <= pend_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o   = (state_q != ST_IDLE);
  assign bus.done_o   = (state_q == ST_DONE) && !bus.flush_i;
  assign bus.result_o = bus.done_o ? pend_q : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN    = 64;
  localparam int MUL_LAT = 2;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef MULDIV_WORD_OPS_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) mif ();

  muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference results straight from the M-extension arithmetic rules.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [127:0] pa, pb, pp;
    longint sa, sb;
    int wa, wb;
    int unsigned ua, ub;
    logic [31:0] w;
    sa = a; sb = b;
    wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    case (op)
      MD_MUL:    return a * b;
      MD_MULH:   begin pa = $signed(a); pb = $signed(b); pp = pa * pb; return pp[127:64]; end
      MD_MULHSU: begin pa = $signed(a); pb = {64'd0, b}; pp = pa * pb; return pp[127:64]; end
      MD_MULHU:  begin pa = {64'd0, a}; pb = {64'd0, b}; pp = pa * pb; return pp[127:64]; end
      MD_DIV:    begin
        if (b == 0) return ALL1;
        if (a == MIN64 && b == ALL1) return a;
        return 64'(sa / sb);
      end
      MD_DIVU:   return (b == 0) ? ALL1 : a / b;
      MD_REM:    begin
        if (b == 0) return a;
        if (a == MIN64 && b == ALL1) return 64'd0;
        return 64'(sa % sb);
      end
      MD_REMU:   return (b == 0) ? a : a % b;
`ifdef MULDIV_WORD_OPS_EN
      MD_MULW:   begin w = a[31:0] * b[31:0]; return sx32(w); end
      MD_DIVW:   begin
        if (wb == 0) return ALL1;
        if (wa == 32'sh8000_0000 && wb == -1) return sx32(32'(wa));
        return sx32(32'(wa / wb));
      end
      MD_DIVUW:  return (ub == 0) ? ALL1 : sx32(32'(ua / ub));
      MD_REMW:   begin
        if (wb == 0) return sx32(32'(wa));
        if (wa == 32'sh8000_0000 && wb == -1) return 64'd0;
        return sx32(32'(wa % wb));
      end
      MD_REMUW:  return (ub == 0) ? sx32(32'(ua)) : sx32(32'(ua % ub));
`endif
      default:   return 64'd0;
    endcase
  endfunction

  function automatic int lat_model(input logic [3:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
    bit legal, word, sgn, zero, ov;
    legal = (op <= 4'd7) || (WORD_EN && (op == MD_MULW || op >= MD_DIVW));
    if (!legal) return 1;
    if (op <= MD_MULHU || op == MD_MULW) return MUL_LAT;
    word = (op >= MD_DIVW);
    sgn  = (op == MD_DIV || op == MD_REM || op == MD_DIVW || op == MD_REMW);
    if (word) begin
      zero = (b[31:0] == 32'd0);
      ov   = sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
    end else begin
      zero = (b == 64'd0);
      ov   = sgn && a == MIN64 && b == ALL1;
    end
    if (zero || ov) return 1;
    return word ? 34 : XLEN + 2;
  endfunction

  // Latency counts the start-sampling edge as 1; busy-time start pulses and
  // operand changes are thrown at the DUT and must have no effect.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
    int n;
    bit seen;
    @(negedge clk);
    mif.start_i = 1'b1; mif.op_i = op; mif.opdata1_i = a; mif.opdata2_i = b;
    @(posedge clk); n = 1; #1;
    mif.start_i = 1'b0;
    mif.opdata1_i = {$urandom, $urandom};
    mif.opdata2_i = {$urandom, $urandom};
    seen = 1'b0;
    while (!seen && n <= 200) begin
      if (mif.done_o) seen = 1'b1;
      else begin
        mif.start_i = 1'($urandom_range(0, 1));
        mif.op_i    = 4'($urandom_range(0, 15));
        @(posedge clk); n++; #1;
      end
    end
    mif.start_i = 1'b0;
    check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
    check_val({tag, "_res"}, mif.result_o, exp_res);
    check_val({tag, "_lat"}, 64'(n), 64'(exp_lat));
    @(posedge clk); #1;
    check_val({tag, "_pulse"}, {62'd0, mif.busy_o, mif.done_o}, 64'd0);
    check_val({tag, "_hold"}, mif.result_o, exp_res);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return ALL1;
      2: return MIN64;
      3: return 64'($urandom_range(0, 20));
      4: return {32'd0, 32'($urandom)};
      5: return {32'hFFFF_FFFF, 32'($urandom)};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin
    int dn;
    logic [3:0]  rop;
    logic [63:0] ra, rb;
    mif.start_i = 1'b0; mif.op_i = '0; mif.opdata1_i = '0; mif.opdata2_i = '0;
    mif.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 64'(mif.busy_o), 64'd0);
    check_val("rst_done", 64'(mif.done_o), 64'd0);
    check_val("rst_res", mif.result_o, 64'd0);
    @(negedge clk); rst = 1'b0;

    do_op("mulh", MD_MULH, -64'sd3, 64'd5, ALL1, MUL_LAT);
    do_op("mulhu", MD_MULHU, ALL1, 64'd2, 64'd1, MUL_LAT);
    do_op("mulhsu", MD_MULHSU, ALL1, 64'd2, ALL1, MUL_LAT);
    do_op("mul", MD_MUL, 64'h1234_5678_9ABC_DEF0, 64'd16, 64'h2345_6789_ABCD_EF00, MUL_LAT);
    do_op("div0", MD_DIV, 64'd5, 64'd0, ALL1, 1);
    do_op("remu0", MD_REMU, 64'd5, 64'd0, 64'd5, 1);
    do_op("div_ovf", MD_DIV, MIN64, ALL1, MIN64, 1);
    do_op("rem_ovf", MD_REM, MIN64, ALL1, 64'd0, 1);
    do_op("div", MD_DIV, -64'sd7, 64'd2, -64'sd3, 66);
    do_op("rem", MD_REM, -64'sd7, 64'd2, ALL1, 66);
    do_op("divu", MD_DIVU, 64'd100, 64'd7, 64'd14, 66);
    do_op("illegal", 4'd9, 64'd3, 64'd4, 64'd0, 1);

    // Flush at divide iteration 20: no done, result_o keeps 0
    @(negedge clk);
    mif.start_i = 1'b1; mif.op_i = MD_DIV; mif.opdata1_i = 64'd1000; mif.opdata2_i = 64'd3;
    @(posedge clk); #1;
    mif.start_i = 1'b0;
    repeat (20) @(posedge clk);
    #1; mif.flush_i = 1'b1;
    @(posedge clk); #1; mif.flush_i = 1'b0;
    check_val("flush_busy", 64'(mif.busy_o), 64'd0);
    check_val("flush_done", 64'(mif.done_o), 64'd0);
    check_val("flush_res", mif.result_o, 64'd0);
    dn = 0;
    repeat (80) begin @(posedge clk); #1; if (mif.done_o) dn++; end
    check_val("flush_nodone", 64'(dn), 64'd0);

    do_op("mul67", MD_MUL, 64'd6, 64'd7, 64'd42, MUL_LAT);

    // flush together with start in IDLE drops the start
    @(negedge clk);
    mif.start_i = 1'b1; mif.flush_i = 1'b1; mif.op_i = MD_MUL;
    mif.opdata1_i = 64'd2; mif.opdata2_i = 64'd3;
    @(posedge clk); #1;
    mif.start_i = 1'b0; mif.flush_i = 1'b0;
    check_val("fstart_busy", 64'(mif.busy_o), 64'd0);
    dn = 0;
    repeat (5) begin @(posedge clk); #1; if (mif.done_o) dn++; end
    check_val("fstart_nodone", 64'(dn), 64'd0);

    // flush in DONE suppresses the pulse and keeps the old result
    @(negedge clk);
    mif.start_i = 1'b1; mif.op_i = MD_DIVU; mif.opdata1_i = 64'd9; mif.opdata2_i = 64'd0;
    @(posedge clk); #1;
    mif.start_i = 1'b0; mif.flush_i = 1'b1;
    #1;
    check_val("fdone_done", 64'(mif.done_o), 64'd0);
    check_val("fdone_res", mif.result_o, 64'd42);
    @(posedge clk); #1; mif.flush_i = 1'b0;
    check_val("fdone_busy", 64'(mif.busy_o), 64'd0);
    check_val("fdone_hold", mif.result_o, 64'd42);

`ifdef MULDIV_WORD_OPS_EN
    do_op("divw", MD_DIVW, 64'h1_0000_0009, 64'd2, 64'd4, 34);
    do_op("mulw", MD_MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT);
    do_op("remuw0", MD_REMUW, 64'h8000_0005, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0005, 1);
`else
    do_op("divw", MD_DIVW, 64'h1_0000_0009, 64'd2, 64'd0, 1);
    do_op("mulw", MD_MULW, 64'h7FFF_FFFF, 64'd2, 64'd0, 1);
`endif

    do_op("pre_rst", MD_DIVU, 64'd77, 64'd7, 64'd11, 66);
    // Asynchronous reset mid-divide: outputs clear without a clock edge
    @(negedge clk);
    mif.start_i = 1'b1; mif.op_i = MD_DIV; mif.opdata1_i = 64'd12345; mif.opdata2_i = 64'd7;
    @(posedge clk); #1;
    mif.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    check_val("arst_busy", 64'(mif.busy_o), 64'd0);
    check_val("arst_done", 64'(mif.done_o), 64'd0);
    check_val("arst_res", mif.result_o, 64'd0);
    @(negedge clk); rst = 1'b0;
    dn = 0;
    repeat (70) begin @(posedge clk); #1; if (mif.done_o) dn++; end
    check_val("arst_nodone", 64'(dn), 64'd0);
    do_op("post_rst", MD_MUL, 64'd3, 64'd4, 64'd12, MUL_LAT);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = pick();
      rb  = pick();
      do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb),
            lat_model(rop, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
